// File: rtl/lsu_rmw.sv
// lsu_rmw: load/store unit with read-modify-write for byte/halfword stores; define LSU_MISALIGN_TRAP_EN to trap misaligned accesses
module lsu_rmw #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;
  state_t state_q, state_d;
  logic we_q, we_d, err_q, err_d;
  logic [2:0] f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d, ext, merged;
  logic [7:0] lb;
  logic [15:0] lh;
  logic ill, mis;
  assign ill = req_we ? (req_funct3[2] | req_funct3 == 3'b011)
                      : (req_funct3 == 3'b011 | req_funct3[2:1] == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
  assign mis = (req_funct3[1:0] == 2'b01 & req_addr[0]) | (req_funct3[1:0] == 2'b10 & |req_addr[1:0]);
`else
  assign mis = 1'b0;
`endif
  assign lb = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign lh = mem_rdata[{addr_q[1], 4'b0000} +: 16];
  assign ext = f3_q == 3'b000 ? {{24{lb[7]}}, lb} :
               f3_q == 3'b001 ? {{16{lh[15]}}, lh} :
               f3_q == 3'b100 ? {24'h0, lb} :
               f3_q == 3'b101 ? {16'h0, lh} : mem_rdata;
  // splice the store byte/halfword into the word just read
  always_comb begin
    merged = mem_rdata;
    if (f3_q[0]) merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    else merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
  end
  // state and latched request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= 3'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      err_q   <= err_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
  // next-state: sequencing plus datapath updates
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    err_d   = err_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (req_valid) begin
        we_d    = req_we;
        f3_d    = req_funct3;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        rdata_d = 32'h0;
        err_d   = ill | mis;
        state_d = (ill | mis) ? RESP : !req_we ? LOAD : req_funct3[1:0] == 2'b10 ? WRITE : RMW_RD;
      end
      LOAD: begin
        rdata_d = ext;
        state_d = RESP;
      end
      RMW_RD: begin
        wdata_d = merged;
        state_d = WRITE;
      end
      WRITE: state_d = RESP;
      RESP: state_d = resp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  // outputs decoded from state; write strobe is blocked while reset is asserted
  always_comb begin
    req_ready  = (state_q == IDLE) & ~rst;
    resp_valid = state_q == RESP;
    resp_rdata = resp_valid ? rdata_q : 32'h0;
    resp_err   = resp_valid & err_q;
    mem_read   = (state_q == LOAD) | (state_q == RMW_RD);
    mem_write  = (state_q == WRITE) & ~rst;
    mem_addr   = (mem_read | mem_write) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    mem_wdata  = mem_write ? wdata_q : 32'h0;
  end
  logic unused;
  assign unused = we_q;
endmodule

// File: tb/tb_lsu_rmw.sv
// tb_lsu_rmw: scoreboard-driven bench for lsu_rmw with a word memory model
module tb_lsu_rmw;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready, req_we = 0;
  logic [2:0] req_funct3 = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic resp_valid, resp_ready = 1, resp_err;
  logic [31:0] resp_rdata;
  logic mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [0:255];
  logic pre_we = 0;
  logic [7:0] pre_a = 0;
  logic [31:0] pre_d = 0, last_wd = 0;
  int nrd = 0, nwr = 0;
  logic overlap = 0;
  int errors = 0, checks = 0;
  typedef struct {logic [31:0] rd; logic e; int lat;} exp_t;
  exp_t sb[$];

  lsu_rmw dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (pre_we) mem[pre_a] <= pre_d;
    if (mem_write) begin
      mem[mem_addr[9:2]] <= mem_wdata;
      last_wd <= mem_wdata;
      nwr <= nwr + 1;
    end
    if (mem_read) nrd <= nrd + 1;
    if (mem_read && mem_write) overlap <= 1'b1;
  end

  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1; pre_a = a; pre_d = d;
    @(negedge clk);
    pre_we = 0;
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       output int lat, output logic [31:0] rd, output logic e);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    req_valid = 1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 0;
    lat = 1;
    while (!resp_valid && lat < 20) begin @(posedge clk); #1 lat++; end
    rd = resp_rdata;
    e = resp_err;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_err, mem_read, mem_write} !== 5'b0) begin
      errors++; $display("FAIL reset_strobes got %b want 00000", {req_ready, resp_valid, resp_err, mem_read, mem_write});
    end
    checks++;
    if ((mem_addr | mem_wdata | resp_rdata) !== 32'h0) begin
      errors++; $display("FAIL reset_buses got %h/%h/%h want 0", mem_addr, mem_wdata, resp_rdata);
    end
    @(negedge clk);
    rst = 0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready); end
  endtask

  task automatic test_loads();
    logic [2:0] f [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b100};
    logic [31:0] ad [7] = '{32'h41, 32'h41, 32'h42, 32'h42, 32'h40, 32'h43, 32'h40};
    logic [31:0] ex [7] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h00008899, 32'h8899AABB, 32'hFFFFFF88, 32'h000000BB};
    int lat; logic [31:0] rd; logic e; exp_t x;
    poke(8'h10, 32'h8899AABB);
    for (int i = 0; i < 7; i++) begin
      sb.push_back('{ex[i], 1'b0, 2});
      issue(1'b0, f[i], ad[i], 32'h0, lat, rd, e);
      x = sb.pop_front();
      checks++;
      if (rd !== x.rd || e !== x.e || lat != x.lat) begin
        errors++; $display("FAIL load%0d got rd=%h err=%b lat=%0d want rd=%h err=%b lat=%0d", i, rd, e, lat, x.rd, x.e, x.lat);
      end
    end
  endtask

  task automatic test_rmw();
    int lat, r0, w0; logic [31:0] rd; logic e; exp_t x;
    poke(8'h10, 32'h11223344);
    r0 = nrd; w0 = nwr;
    sb.push_back('{32'h0, 1'b0, 3});
    issue(1'b1, 3'b000, 32'h42, 32'h123456EE, lat, rd, e);
    x = sb.pop_front();
    checks++;
    if (rd !== x.rd || e !== x.e || lat != x.lat) begin
      errors++; $display("FAIL sb_resp got rd=%h err=%b lat=%0d want rd=%h err=%b lat=%0d", rd, e, lat, x.rd, x.e, x.lat);
    end
    checks++;
    if (last_wd !== 32'h11EE3344 || mem[8'h10] !== 32'h11EE3344) begin
      errors++; $display("FAIL sb_wdata got %h mem=%h want 11ee3344", last_wd, mem[8'h10]);
    end
    checks++;
    if (nrd - r0 != 1 || nwr - w0 != 1) begin
      errors++; $display("FAIL sb_strobes got rd=%0d wr=%0d want 1/1", nrd - r0, nwr - w0);
    end
    sb.push_back('{32'h0, 1'b0, 3});
    issue(1'b1, 3'b001, 32'h40, 32'h7777BEEF, lat, rd, e);
    x = sb.pop_front();
    checks++;
    if (rd !== x.rd || e !== x.e || lat != x.lat || mem[8'h10] !== 32'h11EEBEEF) begin
      errors++; $display("FAIL sh_resp got rd=%h err=%b lat=%0d mem=%h want lat=%0d mem=11eebeef", rd, e, lat, mem[8'h10], x.lat);
    end
  endtask

  task automatic test_sw_lw();
    int lat; logic [31:0] rd; logic e; exp_t x;
    sb.push_back('{32'h0, 1'b0, 2});
    sb.push_back('{32'hDEADBEEF, 1'b0, 2});
    issue(1'b1, 3'b010, 32'h80, 32'hDEADBEEF, lat, rd, e);
    x = sb.pop_front();
    checks++;
    if (rd !== x.rd || e !== x.e || lat != x.lat) begin
      errors++; $display("FAIL sw got rd=%h err=%b lat=%0d want rd=%h err=%b lat=%0d", rd, e, lat, x.rd, x.e, x.lat);
    end
    issue(1'b0, 3'b010, 32'h80, 32'h0, lat, rd, e);
    x = sb.pop_front();
    checks++;
    if (rd !== x.rd || e !== x.e || lat != x.lat) begin
      errors++; $display("FAIL lw got rd=%h err=%b lat=%0d want rd=%h err=%b lat=%0d", rd, e, lat, x.rd, x.e, x.lat);
    end
  endtask

  task automatic test_illegal();
    logic w [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0] f [5] = '{3'b011, 3'b110, 3'b111, 3'b011, 3'b100};
    int lat, r0, w0; logic [31:0] rd; logic e; exp_t x;
    r0 = nrd; w0 = nwr;
    for (int i = 0; i < 5; i++) begin
      sb.push_back('{32'h0, 1'b1, 1});
      issue(w[i], f[i], 32'h40, 32'hFFFFFFFF, lat, rd, e);
      x = sb.pop_front();
      checks++;
      if (rd !== x.rd || e !== x.e || lat != x.lat) begin
        errors++; $display("FAIL illegal%0d got rd=%h err=%b lat=%0d want rd=%h err=%b lat=%0d", i, rd, e, lat, x.rd, x.e, x.lat);
      end
    end
    checks++;
    if (nrd != r0 || nwr != w0) begin errors++; $display("FAIL illegal_strobes got rd=%0d wr=%0d want 0/0", nrd - r0, nwr - w0); end
  endtask

  task automatic test_misalign();
    logic [2:0] f [2] = '{3'b010, 3'b001};
    logic [31:0] ad [2] = '{32'h42, 32'h41};
`ifdef LSU_MISALIGN_TRAP_EN
    exp_t ex [2] = '{'{32'h0, 1'b1, 1}, '{32'h0, 1'b1, 1}};
    int ereads = 0;
`else
    exp_t ex [2] = '{'{32'h8899AABB, 1'b0, 2}, '{32'hFFFFAABB, 1'b0, 2}};
    int ereads = 2;
`endif
    int lat, r0; logic [31:0] rd; logic e; exp_t x;
    poke(8'h10, 32'h8899AABB);
    r0 = nrd;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(ex[i]);
      issue(1'b0, f[i], ad[i], 32'h0, lat, rd, e);
      x = sb.pop_front();
      checks++;
      if (rd !== x.rd || e !== x.e || lat != x.lat) begin
        errors++; $display("FAIL misalign%0d got rd=%h err=%b lat=%0d want rd=%h err=%b lat=%0d", i, rd, e, lat, x.rd, x.e, x.lat);
      end
    end
    checks++;
    if (nrd - r0 != ereads) begin errors++; $display("FAIL misalign_reads got %0d want %0d", nrd - r0, ereads); end
  endtask

  task automatic test_backpressure();
    int lat, w0; logic [31:0] rd; logic e; exp_t x;
    w0 = nwr;
    resp_ready = 0;
    sb.push_back('{32'h0, 1'b0, 2});
    issue(1'b1, 3'b010, 32'h84, 32'h0BADF00D, lat, rd, e);
    x = sb.pop_front();
    checks++;
    if (lat != x.lat || e !== x.e) begin errors++; $display("FAIL bp_resp got lat=%0d err=%b want lat=%0d err=%b", lat, e, x.lat, x.e); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({resp_valid, resp_err, req_ready} !== 3'b100 || resp_rdata !== 32'h0) begin
        errors++; $display("FAIL bp_hold%0d got v/e/rdy=%b rd=%h want 100 rd=0", i, {resp_valid, resp_err, req_ready}, resp_rdata);
      end
      @(posedge clk); #1;
    end
    resp_ready = 1;
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1'b0 || nwr - w0 != 1 || mem[8'h21] !== 32'h0BADF00D) begin
      errors++; $display("FAIL bp_done got valid=%b writes=%0d mem=%h want 0/1/0badf00d", resp_valid, nwr - w0, mem[8'h21]);
    end
  endtask

  task automatic test_rst_mid();
    int w0;
    poke(8'h10, 32'h11223344);
    w0 = nwr;
    @(negedge clk);
    req_valid = 1; req_we = 1; req_funct3 = 3'b000; req_addr = 32'h42; req_wdata = 32'hEE;
    @(posedge clk);
    #1 req_valid = 0;
    @(posedge clk);
    #1;
    checks++;
    if (mem_write !== 1'b1) begin errors++; $display("FAIL rst_in_write got mem_write=%b want 1", mem_write); end
    rst = 1;
    @(posedge clk);
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_err, mem_read, mem_write} !== 5'b0 || (mem_addr | mem_wdata | resp_rdata) !== 32'h0) begin
      errors++; $display("FAIL rst_mid_outputs got %b %h %h %h want 0", {req_ready, resp_valid, resp_err, mem_read, mem_write}, mem_addr, mem_wdata, resp_rdata);
    end
    checks++;
    if (mem[8'h10] !== 32'h11223344 || nwr != w0) begin
      errors++; $display("FAIL rst_mid_mem got %h writes=%0d want 11223344 0", mem[8'h10], nwr - w0);
    end
    @(negedge clk);
    rst = 0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %b want 1", req_ready); end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_rmw();
    test_sw_lw();
    test_illegal();
    test_misalign();
    test_backpressure();
    test_rst_mid();
    checks++;
    if (overlap !== 1'b0) begin errors++; $display("FAIL strobe_overlap got %b want 0", overlap); end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d want 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lsu_rmw.md
# lsu_rmw

Load/store unit between the core's execute stage and the word-addressed data memory. Accepts one load or store request at a time, converts it to word-aligned memory accesses, and returns the result on a response handshake. Loads produce sign- or zero-extended results. Byte and halfword stores use a read-modify-write sequence, because the memory only supports full-word writes.

## Interface
- `ADDR_W`, default 32: request and memory address width.
- `clk`  in  1: clock; everything updates on the rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: request accepted when `req_valid & req_ready`.
- `req_we`  in  1: 1 = store, 0 = load.
- `req_funct3`  in  3: RV32I width code.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- `req_addr`  in  ADDR_W: byte address.
- `req_wdata`  in  32: store data; the low byte or halfword is used for SB/SH.
- `resp_valid`  out  1: response present.
- `resp_ready`  in  1: response consumed when `resp_valid & resp_ready`.
- `resp_rdata`  out  32: extended load data; 0 for stores and errors.
- `resp_err`  out  1: illegal or misaligned request.
- `mem_read`  out  1: memory read strobe. Memory read data is combinational in the same cycle.
- `mem_write`  out  1: memory write strobe. Memory commits on the next rising edge.
- `mem_addr`  out  ADDR_W: `{addr[ADDR_W-1:2], 2'b00}`.
- `mem_wdata`  out  32: full word to write.
- `mem_rdata`  in  32: word read from memory.

## Operation
- States:
  - IDLE, LOAD, RMW_RD, WRITE, RESP.
  - Request fields are latched on acceptance.
- IDLE:
  - `req_ready` = 1.
  - On acceptance, the next state is one of:
    - RESP with error, for an illegal funct3 or a misaligned address (see Configuration);
    - LOAD, for a legal load;
    - WRITE, for SW;
    - RMW_RD, for SB/SH.
- LOAD:
  - Drives `mem_read` = 1 and `mem_addr`.
  - Selects the lane by `addr[1:0]`: byte lane `addr[1:0]*8`, halfword lane `addr[1]*16`.
  - Extension: LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
  - Registers the result into `resp_rdata`, then goes to RESP.
- RMW_RD:
  - Drives `mem_read` = 1.
  - Registers `mem_rdata` with the addressed byte or halfword replaced by `req_wdata[7:0]` or `req_wdata[15:0]`.
  - Goes to WRITE.
- WRITE:
  - Drives `mem_write` = 1 and `mem_wdata` (the merged word, or `req_wdata` for SW).
  - Goes to RESP.
- RESP:
  - `resp_valid` = 1.
  - Holds `resp_rdata` and `resp_err` stable until `resp_ready`, then returns to IDLE.
- `mem_read` and `mem_write` are never both high.
  - Both are 0 in IDLE and RESP.
  - `mem_addr` and `mem_wdata` are 0 whenever their strobe is low.
- Illegal funct3:
  - Loads: 011, 110, 111.
  - Stores: 011 and anything with bit 2 set.
  - These always give `resp_err` = 1 with no memory access.

## Timing
- Reset:
  - State is IDLE.
  - `resp_valid`, `resp_rdata`, `resp_err`, `mem_read`, `mem_write`, `mem_addr` and `mem_wdata` are all 0.
  - `req_ready` = 0 while `rst` is high.
- Reset mid-operation:
  - Aborts the operation with no response.
  - `mem_write` is gated by `~rst`, so no write commits on the edge where reset is sampled.
  - An RMW interrupted in RMW_RD leaves memory unchanged.
- Latency from acceptance edge (cycle 0) to the first `resp_valid` cycle:
  - Load: 2.
  - SW: 2.
  - SB/SH: 3.
  - Error: 1.
- Throughput: at most one request in flight. `req_ready` is high only in IDLE, so back-to-back accepts are spaced by latency + 1 cycles when `resp_ready` is held high.
- Backpressure: `resp_ready` low stalls in RESP indefinitely. The memory write has already committed at that point.
- Address wrap: top address bits are passed through unchanged. The memory decodes only its own range.

## Configuration
- Macro: `LSU_MISALIGN_TRAP_EN`.
- Defined:
  - LH/LHU/SH with `addr[0]` = 1, or LW/SW with `addr[1:0]` ≠ 0, give `resp_err` = 1 with no memory access.
- Undefined:
  - Misaligned addresses are silently aligned: halfword lane `addr[1]*16`, word with `addr[1:0]` ignored.
  - `resp_err` is raised only for illegal funct3.

## Test plan
- Word 0x40 preloaded with 0x8899AABB; LB at 0x41 -> `resp_rdata` 0xFFFFFFAA two cycles after accept; LBU at 0x41 -> 0x000000AA; LH at 0x42 -> 0xFFFF8899.
- Word 0x40 = 0x11223344; SB 0xEE at 0x42 -> one `mem_read` cycle, then `mem_write` with `mem_wdata` 0x11EE3344; response at cycle 3.
- SW 0xDEADBEEF at 0x80, then LW at 0x80 -> 0xDEADBEEF; `mem_read` and `mem_write` never overlap.
- With the macro defined, LW at 0x42 -> `resp_err` = 1 at cycle 1 and no strobes. Without it, the same request reads word 0x40 with `resp_err` = 0.
- `resp_ready` held low 5 cycles after SW -> `resp_valid` and `resp_err` stay stable, `req_ready` = 0, exactly one `mem_write` pulse.
- `rst` asserted in the WRITE cycle of an SB -> no memory change, all outputs 0 next cycle, `req_ready` = 1 after `rst` drops.
